riscv_boot_ctrl: RTL and testbench

Boot and run sequencer for the RV32I single-cycle core. The block holds the core in reset, receives a program as a little-endian byte stream, and writes it word by word into instruction memory. It then releases the core's reset and supervises the run until the core signals halt or an optional watchdog expires. It sits between the bench or host loader and the `singlecycle` core plus `riscv_imem` write port.

---
 rtl/riscv_boot_pkg.sv | 16 +
 rtl/riscv_boot_packer.sv | 32 +++
 rtl/riscv_boot_ctrl.sv | 166 ++++++++++++++++
 tb/tb_riscv_boot_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_boot_pkg.sv
// Shared types and defaults for the RV32I boot/run sequencer.
// Holds the FSM encoding, default IMEM width and watchdog limit.
package riscv_boot_pkg;

  localparam int ADDR_BIT_DEF   = 10;
  localparam int WDT_CYCLES_DEF = 100;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/riscv_boot_packer.sv
// Byte-to-word packer for the boot stream.
// Fills a 32-bit word little-endian, flags the 4th byte.
module riscv_boot_packer
  import riscv_boot_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_clr,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [1:0] byte_cnt;

  // Drop each accepted byte into its lane and advance the lane counter
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      byte_cnt <= '0;
      o_word   <= '0;
    end else if (i_clr) begin
      byte_cnt <= '0;
    end else if (i_valid) begin
      o_word[{byte_cnt, 3'b000} +: 8] <= i_byte;
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  assign o_word_valid = i_valid & (byte_cnt == 2'd3);

endmodule

// File: rtl/riscv_boot_ctrl.sv
// Boot loader and run supervisor for the single-cycle core.
// Optional watchdog: define RISCV_BOOT_WDT_EN.
module riscv_boot_ctrl
  import riscv_boot_pkg::*;
#(
  parameter int P_ADDR_BIT   = ADDR_BIT_DEF,
  parameter int P_WDT_CYCLES = WDT_CYCLES_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_start,
  input  logic [P_ADDR_BIT-2:0] i_len,
  input  logic                  i_byte_valid,
  input  logic [7:0]            i_byte,
  output logic                  o_byte_ready,
  output logic                  o_imem_we,
  output logic [P_ADDR_BIT-1:0] o_imem_addr,
  output logic [31:0]           o_imem_wdata,
  input  logic                  i_halt,
  output logic                  o_core_rstn,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int WB = P_ADDR_BIT - 2;
  localparam int LB = P_ADDR_BIT - 1;
  localparam logic [LB-1:0] CAP = LB'(2 ** WB);

  state_t        state_q;
  state_t        state_d;
  logic [LB-1:0] len_q;
  logic [LB-1:0] len_clamp;
  logic [WB-1:0] word_idx;
  logic          start_ok;
  logic          last_word;
  logic          run_exit;
  logic          pk_valid;
  logic          word_valid;
  logic [31:0]   word;

  assign start_ok  = i_start &
                     ((state_q == S_IDLE) |
                      (state_q == S_DONE));
  assign len_clamp = (i_len > CAP) ? CAP : i_len;
  assign last_word = ({1'b0, word_idx} ==
                      (len_q - LB'(1)));
  assign pk_valid  = i_byte_valid &
                     (state_q == S_LOAD);

  riscv_boot_packer u_packer (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_clr        (start_ok),
    .i_valid      (pk_valid),
    .i_byte       (i_byte),
    .o_word       (word),
    .o_word_valid (word_valid)
  );

`ifdef RISCV_BOOT_WDT_EN
  localparam int RCW = $clog2(P_WDT_CYCLES + 1);

  logic [RCW-1:0] run_cnt;
  logic           timeout;
  logic           err_q;

  assign timeout  = (state_q == S_RUN) &
                    (run_cnt == RCW'(P_WDT_CYCLES - 1));
  assign run_exit = i_halt | timeout;
  assign o_err    = err_q;

  // Count core-active cycles; cleared on every accepted start
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      run_cnt <= '0;
    end else if (start_ok) begin
      run_cnt <= '0;
    end else if (state_q == S_RUN) begin
      run_cnt <= run_cnt + RCW'(1);
    end
  end

  // Flag a timeout exit; a coincident halt takes priority
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      err_q <= 1'b0;
    end else if (start_ok) begin
      err_q <= 1'b0;
    end else if (timeout & ~i_halt) begin
      err_q <= 1'b1;
    end
  end
`else
  assign run_exit = i_halt;
  assign o_err    = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_d      = state_q;
    o_byte_ready = 1'b0;
    o_imem_we    = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        o_done = (state_q == S_DONE);
        if (i_start) begin
          state_d = (i_len == '0) ? S_RUN : S_LOAD;
        end
      end
      S_LOAD: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b1;
        if (word_valid) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        o_imem_we = 1'b1;
        o_busy    = 1'b1;
        state_d   = last_word ? S_RUN : S_LOAD;
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (run_exit) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Length latch, word index and the registered core reset
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      len_q       <= '0;
      word_idx    <= '0;
      o_core_rstn <= 1'b0;
    end else begin
      o_core_rstn <= (state_d == S_RUN);
      if (start_ok) begin
        len_q    <= len_clamp;
        word_idx <= '0;
      end else if ((state_q == S_WRITE) & ~last_word) begin
        word_idx <= word_idx + WB'(1);
      end
    end
  end

  assign o_imem_addr  = {word_idx, 2'b00};
  assign o_imem_wdata = word;

endmodule

// File: tb/tb_riscv_boot_ctrl.sv
// Self-checking bench for riscv_boot_ctrl.
// Watchdog scenarios follow RISCV_BOOT_WDT_EN.
module tb_riscv_boot_ctrl;

  localparam int AB  = 10;
  localparam int WDT = 100;
  localparam int CAP = 256;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_start = 1'b0;
  logic [8:0]  i_len = '0;
  logic        i_byte_valid = 1'b0;
  logic [7:0]  i_byte = '0;
  logic        i_halt = 1'b0;
  logic        o_byte_ready;
  logic        o_imem_we;
  logic [9:0]  o_imem_addr;
  logic [31:0] o_imem_wdata;
  logic        o_core_rstn;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  int cmp = 0;
  int bad = 0;
  int cyc = 0;
  int rstn_hi = 0;
  int t0 = 0;
  int run_seen = 0;

  logic [9:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];

  riscv_boot_ctrl #(
    .P_ADDR_BIT   (AB),
    .P_WDT_CYCLES (WDT)
  ) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_start      (i_start),
    .i_len        (i_len),
    .i_byte_valid (i_byte_valid),
    .i_byte       (i_byte),
    .o_byte_ready (o_byte_ready),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_wdata (o_imem_wdata),
    .i_halt       (i_halt),
    .o_core_rstn  (o_core_rstn),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe writes and core-active cycles
  always @(negedge clk) begin
    if (o_imem_we) begin
      wa_q.push_back(o_imem_addr);
      wd_q.push_back(o_imem_wdata);
      wc_q.push_back(cyc);
    end
    if (o_core_rstn) rstn_hi++;
  end

  task automatic do_start(input int len);
    @(negedge clk);
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    rstn_hi = 0;
    i_start = 1'b1;
    i_len = 9'(len);
    @(negedge clk);
    i_start = 1'b0;
    t0 = cyc;
  endtask

  // mode 0: continuous, 1: alternating low-first, 2: random gaps
  task automatic stream(input logic [7:0] b[$],
                        input int mode, input int limit);
    int i = 0;
    int k = 0;
    logic v;
    logic rdy;
    while (i < limit && k < 5000) begin
      rdy = o_byte_ready;
      case (mode)
        0: v = 1'b1;
        1: v = (k % 2 == 1);
        default: v = ($urandom_range(0, 9) < 6);
      endcase
      i_byte_valid = v;
      i_byte = b[i];
      @(negedge clk);
      if (v && rdy) i++;
      k++;
    end
    i_byte_valid = 1'b0;
    cmp++;
    if (i != limit) begin
      bad++;
      $display("FAIL stream_accept got %0d need %0d", i, limit);
    end
  endtask

  task automatic wait_run(input int budget);
    int n = 0;
    while (!o_core_rstn && n < budget) begin
      @(negedge clk);
      n++;
    end
    run_seen = cyc;
    cmp++;
    if (o_core_rstn !== 1'b1) begin
      bad++;
      $display("FAIL wait_run rstn=%b need 1", o_core_rstn);
    end
  endtask

  task automatic check_writes(input logic [7:0] b[$],
                              input int n);
    logic [31:0] w;
    cmp++;
    if (wa_q.size() != n) begin
      bad++;
      $display("FAIL write_count got %0d need %0d",
               wa_q.size(), n);
    end
    for (int k = 0; k < n && k < wa_q.size(); k++) begin
      w = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
      cmp++;
      if (wa_q[k] !== 10'(4*k) || wd_q[k] !== w) begin
        bad++;
        $display("FAIL write_%0d got %h:%h need %h:%h",
                 k, wa_q[k], wd_q[k], 10'(4*k), w);
      end
    end
  endtask

  // halt must be issued while running; checks DONE outputs
  task automatic halt_check(input int hold, input int exp_hi);
    repeat (hold) @(negedge clk);
    i_halt = 1'b1;
    @(negedge clk);
    i_halt = 1'b0;
    cmp++;
    if ({o_done, o_err, o_core_rstn, o_busy} !== 4'b1000) begin
      bad++;
      $display("FAIL halt_state got %b need 1000",
               {o_done, o_err, o_core_rstn, o_busy});
    end
    cmp++;
    if (rstn_hi != exp_hi) begin
      bad++;
      $display("FAIL run_cycles got %0d need %0d",
               rstn_hi, exp_hi);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #12;
    cmp++;
    if ({o_byte_ready, o_imem_we, o_busy, o_done, o_err,
         o_core_rstn, o_imem_addr, o_imem_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_vals got %b%b%b%b%b%b %h %h need 0",
               o_byte_ready, o_imem_we, o_busy, o_done,
               o_err, o_core_rstn, o_imem_addr, o_imem_wdata);
    end
    @(negedge clk);
    rstn = 1'b1;
    i_halt = 1'b1;
    i_byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    i_halt = 1'b0;
    i_byte_valid = 1'b0;
    cmp++;
    if ({o_byte_ready, o_busy, o_done, o_core_rstn} !== 4'b0
        || wa_q.size() != 0) begin
      bad++;
      $display("FAIL idle_ignore got %b%b%b%b w%0d need 0",
               o_byte_ready, o_busy, o_done, o_core_rstn,
               wa_q.size());
    end
  endtask

  task automatic test_load_two();
    logic [7:0] b[$];
    b = '{8'h13, 8'h00, 8'h50, 8'h00,
          8'h93, 8'h00, 8'h10, 8'h00};
    do_start(2);
    stream(b, 0, 8);
    wait_run(20);
    check_writes(b, 2);
    cmp++;
    if (wc_q.size() == 2 &&
        (wc_q[0] - t0 != 4 || wc_q[1] - wc_q[0] != 5)) begin
      bad++;
      $display("FAIL load_timing got %0d,%0d need 4,5",
               wc_q[0] - t0, wc_q[1] - wc_q[0]);
    end
    cmp++;
    if (run_seen - t0 != 10) begin
      bad++;
      $display("FAIL rstn_rise got %0d need 10", run_seen - t0);
    end
    halt_check(3, 4);
  endtask

  task automatic test_gapped();
    logic [7:0] b[$];
    repeat (4) b.push_back(8'($urandom));
    do_start(1);
    stream(b, 1, 4);
    wait_run(20);
    check_writes(b, 1);
    cmp++;
    if (wc_q.size() == 1 && wc_q[0] - t0 != 8) begin
      bad++;
      $display("FAIL gap_timing got %0d need 8", wc_q[0] - t0);
    end
    halt_check(0, 1);
  endtask

  task automatic test_random_loads();
    logic [7:0] b[$];
    int len;
    int h;
    repeat (4) begin
      b.delete();
      len = $urandom_range(1, 6);
      repeat (4 * len) b.push_back(8'($urandom));
      do_start(len);
      stream(b, 2, 4 * len);
      wait_run(40);
      check_writes(b, len);
      h = $urandom_range(0, 20);
      halt_check(h, h + 1);
    end
  endtask

  task automatic test_len_zero();
    do_start(0);
    cmp++;
    if ({o_core_rstn, o_busy, o_byte_ready} !== 3'b110) begin
      bad++;
      $display("FAIL len0_run got %b need 110",
               {o_core_rstn, o_busy, o_byte_ready});
    end
    i_start = 1'b1;
    i_len = 9'd3;
    i_byte_valid = 1'b1;
    repeat (5) @(negedge clk);
    i_start = 1'b0;
    i_byte_valid = 1'b0;
    cmp++;
    if ({o_core_rstn, o_busy, o_byte_ready} !== 3'b110
        || wa_q.size() != 0) begin
      bad++;
      $display("FAIL run_ignore got %b w%0d need 110 w0",
               {o_core_rstn, o_busy, o_byte_ready},
               wa_q.size());
    end
    halt_check(0, 6);
  endtask

  task automatic test_watchdog();
`ifdef RISCV_BOOT_WDT_EN
    int n = 0;
    do_start(0);
    while (!o_done && n < 3 * WDT) begin
      @(negedge clk);
      n++;
    end
    cmp++;
    if ({o_done, o_err, o_core_rstn} !== 3'b110
        || rstn_hi != WDT) begin
      bad++;
      $display("FAIL wdt_expire got %b hi%0d need 110 hi%0d",
               {o_done, o_err, o_core_rstn}, rstn_hi, WDT);
    end
    do_start(0);
    cmp++;
    if (o_err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear got %b need 0", o_err);
    end
    halt_check(WDT - 1, WDT);
`else
    do_start(0);
    repeat (WDT + 50) @(negedge clk);
    cmp++;
    if ({o_busy, o_done, o_err, o_core_rstn} !== 4'b1001) begin
      bad++;
      $display("FAIL no_wdt got %b need 1001",
               {o_busy, o_done, o_err, o_core_rstn});
    end
    halt_check(0, WDT + 51);
`endif
  endtask

  task automatic test_clamp();
    logic [7:0] b[$];
    repeat (4 * CAP) b.push_back(8'($urandom));
    do_start(300);
    stream(b, 0, 4 * CAP);
    wait_run(20);
    check_writes(b, CAP);
    halt_check(1, 2);
  endtask

  task automatic test_async_reset();
    logic [7:0] b[$];
    logic [7:0] c[$];
    repeat (8) b.push_back(8'($urandom));
    do_start(2);
    stream(b, 0, 6);
    check_writes(b, 1);
    i_byte_valid = 1'b1;
    i_byte = b[6];
    #2 rstn = 1'b0;
    #1;
    cmp++;
    if ({o_byte_ready, o_imem_we, o_busy, o_done, o_err,
         o_core_rstn, o_imem_addr, o_imem_wdata} !== '0) begin
      bad++;
      $display("FAIL async_reset got %b%b%b%b%b%b %h %h need 0",
               o_byte_ready, o_imem_we, o_busy, o_done,
               o_err, o_core_rstn, o_imem_addr, o_imem_wdata);
    end
    @(negedge clk);
    i_byte_valid = 1'b0;
    rstn = 1'b1;
    repeat (4) c.push_back(8'($urandom));
    do_start(1);
    stream(c, 0, 4);
    wait_run(20);
    check_writes(c, 1);
    halt_check(0, 1);
  endtask

  initial begin
    test_reset();
    test_load_two();
    test_gapped();
    test_random_loads();
    test_len_zero();
    test_watchdog();
    test_clamp();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp, bad);
    $finish;
  end

endmodule
